// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed FND scan controller: owns the digit prescaler and scan index,
// snapshots the digit bus once per frame, and applies leading-zero blanking, DP and blink.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 250,
    parameter int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]         i_dp_mask,
    input  logic                          i_blank_lz,
    input  logic                          i_blink_en,
    input  logic [NUM_DIGITS-1:0]         i_blink_mask,
    output logic [DIGIT_W-1:0]            o_value,
    output logic [NUM_DIGITS-1:0]         o_digit_sel,
    output logic                          o_dp,
    output logic                          o_blank,
    output logic [IDX_W-1:0]              o_scan_idx
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]      div;
    logic [IDX_W-1:0]      idx;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  phase;
    logic [DIGIT_W-1:0]    snap_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] snap_dp;
    logic                  tick;
    logic                  wrap;
    logic                  upper_zero;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic                  slot_blank;

    assign tick = i_enable && (div == DIV_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // NOTE: all state registers use non-blocking assignments so every process
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div <= '0;
            idx <= '0;
        end else if (i_enable) begin
            if (tick) begin
                div <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // NOTE: the snapshot file is reset on purpose: the first frame after reset
    // must show zeros, so this small register file cannot be left uninitialised.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) snap_digits[k] <= '0;
            snap_dp <= '0;
        end else if (wrap) begin
            for (int k = 0; k < NUM_DIGITS; k++) snap_digits[k] <= i_digits[k*DIGIT_W +: DIGIT_W];
            snap_dp <= i_dp_mask;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            frame_cnt <= '0;
            phase     <= 1'b1;
        end else if (!i_blink_en) begin
            frame_cnt <= '0;
            phase     <= 1'b1;
        end else if (wrap) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // NOTE: defaults first so no path through this block leaves a value held (no latch).
    always_comb begin
        upper_zero = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero  = upper_zero && (snap_digits[k] == '0);
            lz_blank[k] = i_blank_lz && (k != 0) && upper_zero;
        end
    end

    assign slot_blank = !i_enable || lz_blank[idx] || (i_blink_en && !phase && i_blink_mask[idx]);

    // Registered outputs keep the anode lines glitch-free and strictly one-hot.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_value     <= '0;
            o_digit_sel <= '1;
            o_dp        <= 1'b0;
            o_blank     <= 1'b1;
            o_scan_idx  <= '0;
        end else begin
            o_scan_idx <= idx;
            if (slot_blank) begin
                o_value     <= '0;
                o_digit_sel <= '1;
                o_dp        <= 1'b0;
                o_blank     <= 1'b1;
            end else begin
                o_value     <= snap_digits[idx];
                o_digit_sel <= ~(NUM_DIGITS'(1) << idx);
                o_dp        <= snap_dp[idx];
                o_blank     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: a 4-digit instance with blinking and blanking against a
// cycle-count reference model, plus a 3-digit instance for non-power-of-2 wrap.
module tb_fnd_scan_ctrl;

    localparam int N   = 4;
    localparam int SD  = 4;
    localparam int BF  = 2;
    localparam int DW  = 4;
    localparam int N3  = 3;
    localparam int SD3 = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic        blz;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic [3:0]  value;
    logic [3:0]  sel;
    logic        dp;
    logic        blank;
    logic [1:0]  scan_idx;

    logic [11:0] digits3;
    logic [2:0]  dp_mask3;
    logic [3:0]  value3;
    logic [2:0]  sel3;
    logic        dp3;
    logic        blank3;
    logic [1:0]  scan_idx3;

    int checks = 0;
    int errors = 0;

    // Reference model state: counts of enabled cycles and of wraps since blink clear.
    int          en_cnt;
    int          cnt3;
    int          w;
    logic [15:0] snap;
    logic [3:0]  snap_dp;
    logic [11:0] snap3;
    logic [2:0]  snap_dp3;

    fnd_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_W(DW), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_digits(digits),
        .i_dp_mask(dp_mask), .i_blank_lz(blz), .i_blink_en(blink_en),
        .i_blink_mask(blink_mask), .o_value(value), .o_digit_sel(sel),
        .o_dp(dp), .o_blank(blank), .o_scan_idx(scan_idx)
    );

    fnd_scan_ctrl #(.NUM_DIGITS(N3), .DIGIT_W(DW), .SCAN_DIV(SD3), .BLINK_FRAMES(1)) dut3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_enable(1'b1), .i_digits(digits3),
        .i_dp_mask(dp_mask3), .i_blank_lz(1'b0), .i_blink_en(1'b0),
        .i_blink_mask(3'b000), .o_value(value3), .o_digit_sel(sel3),
        .o_dp(dp3), .o_blank(blank3), .o_scan_idx(scan_idx3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        en_cnt   = 0;
        cnt3     = 0;
        w        = 0;
        snap     = '0;
        snap_dp  = '0;
        snap3    = '0;
        snap_dp3 = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_value", 32'(value), 32'h0);
        check("rst_sel", 32'(sel), 32'hF);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_idx", 32'(scan_idx), 32'h0);
        check("rst_sel3", 32'(sel3), 32'h7);
        check("rst_blank3", 32'(blank3), 32'h1);
    endtask

    function automatic int model_idx();
        return (en_cnt / SD) % N;
    endfunction

    // One clock: predict from pre-edge state and inputs, advance the model, check at negedge.
    task automatic step();
        int         idx;
        int         idx3;
        logic       lz;
        logic       blk;
        logic       bl;
        logic       wrap;
        logic [3:0] e_sel;
        logic [3:0] e_val;
        logic       e_dp;
        logic [2:0] e_sel3;
        logic [3:0] e_val3;
        logic       e_dp3;

        digits3  = 12'($urandom);
        dp_mask3 = 3'($urandom);

        idx   = model_idx();
        lz    = blz && (idx != 0) && ((snap >> (idx * DW)) == 16'h0);
        blk   = blink_en && (((w / BF) % 2) == 1) && blink_mask[idx];
        bl    = !en || lz || blk;
        e_sel = bl ? 4'hF : ~(4'b0001 << idx);
        e_val = bl ? 4'h0 : snap[idx*DW +: DW];
        e_dp  = bl ? 1'b0 : snap_dp[idx];

        idx3   = (cnt3 / SD3) % N3;
        e_sel3 = ~(3'b001 << idx3);
        e_val3 = snap3[idx3*DW +: DW];
        e_dp3  = snap_dp3[idx3];

        @(posedge clk);
        wrap = en && ((en_cnt % (SD * N)) == SD * N - 1);
        if (en) en_cnt++;
        if (wrap) begin
            snap    = digits;
            snap_dp = dp_mask;
        end
        if (!blink_en) w = 0;
        else if (wrap) w++;
        if ((cnt3 % (SD3 * N3)) == SD3 * N3 - 1) begin
            snap3    = digits3;
            snap_dp3 = dp_mask3;
        end
        cnt3++;

        @(negedge clk);
        check("sel", 32'(sel), 32'(e_sel));
        check("value", 32'(value), 32'(e_val));
        check("dp", 32'(dp), 32'(e_dp));
        check("blank", 32'(blank), 32'(bl));
        check("scan_idx", 32'(scan_idx), 32'(idx));
        check("sel3", 32'(sel3), 32'(e_sel3));
        check("value3", 32'(value3), 32'(e_val3));
        check("dp3", 32'(dp3), 32'(e_dp3));
        check("blank3", 32'(blank3), 32'h0);
        check("scan_idx3", 32'(scan_idx3), 32'(idx3));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [15:0] tmp;
        logic        found;

        clk        = 1'b0;
        rst_n      = 1'b0;
        en         = 1'b1;
        digits     = '0;
        dp_mask    = '0;
        blz        = 1'b0;
        blink_en   = 1'b0;
        blink_mask = '0;
        digits3    = '0;
        dp_mask3   = '0;
        model_reset();

        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Plain scan: zero frame first, then 6,7,8,9.
        digits = 16'h9876;
        run(3 * SD * N);

        // Leading-zero blanking and decimal point.
        blz     = 1'b1;
        digits  = 16'h0042;
        dp_mask = 4'b0100;
        run(2 * SD * N);
        digits = 16'h0000;
        run(2 * SD * N);

        // Mid-frame digit change.
        blz    = 1'b0;
        digits = 16'h1234;
        run(SD * N + SD + 1);
        digits = 16'h5678;
        run(2 * SD * N);

        // Blinking of digit 0, then blinking disabled.
        blink_en   = 1'b1;
        blink_mask = 4'b0001;
        run(5 * SD * N);
        blink_en = 1'b0;
        run(SD * N);

        // Enable dropped mid-slot, then resumed.
        run(2);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(SD * N);

        // Randomised stimulus.
        blink_en = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                tmp    = 16'($urandom);
                digits = tmp >> (4 * $urandom_range(0, 4));
            end
            if ($urandom_range(0, 29) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 49) == 0) blz = ~blz;
            if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
            if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom);
            en = ($urandom_range(0, 15) != 0);
            step();
        end

        // Asynchronous reset in the middle of the slot at index 2.
        en    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (model_idx() == 2) found = 1'b1;
            else step();
        end
        check("reach_idx2", 32'(found), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        digits = 16'h4321;
        run(3 * SD * N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
